// File: rtl/width_adapter.sv
// width_adapter: repacks IW-bit words into OW-bit words as one MSB-first bitstream; in: clk rst idata ivalid oready, out: iready odata ovalid
module width_adapter #(
  parameter int IW = 64,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] idata,
  input  logic          ivalid,
  output logic          iready,
  output logic [OW-1:0] odata,
  output logic          ovalid,
  input  logic          oready
);
  localparam int BUFW = IW + OW;
  localparam int CW = $clog2(BUFW + 1);
  logic [BUFW-1:0] r_buf;
  logic [CW-1:0]   r_cnt;
  logic            w_in;
  logic            w_out;
  logic [BUFW-1:0] w_sh;
  logic [BUFW-1:0] w_mask;
  logic [BUFW-1:0] w_ins;
  logic [CW-1:0]   w_cnt;
  assign ovalid = r_cnt >= CW'(OW);
  assign iready = r_cnt <= CW'(OW);
  assign odata  = r_buf[BUFW-1 -: OW];
  assign w_in   = ivalid && iready;
  assign w_out  = ovalid && oready;
  assign w_sh   = w_out ? r_buf << OW : r_buf;
  assign w_cnt  = w_out ? r_cnt - CW'(OW) : r_cnt;
  assign w_mask = ~({BUFW{1'b1}} >> w_cnt);
  assign w_ins  = {idata, {OW{1'b0}}} >> w_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_in ? (w_sh & w_mask) | w_ins : w_sh;
      r_cnt <= w_in ? w_cnt + CW'(IW) : w_cnt;
    end
  end
endmodule

// File: tb/tb_width_adapter.sv
// tb_width_adapter: directed and scoreboarded checks of width_adapter in 64/32, 32/64 and 24/16 configurations
module tb_width_adapter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [63:0] a_idata;
  logic        a_ivalid, a_iready, a_ovalid, a_oready;
  logic [31:0] a_odata;
  logic [31:0] b_idata;
  logic        b_ivalid, b_iready, b_ovalid, b_oready;
  logic [63:0] b_odata;
  logic [23:0] c_idata;
  logic        c_ivalid, c_iready, c_ovalid, c_oready;
  logic [15:0] c_odata;
  int total = 0;
  int bad = 0;
  width_adapter #(.IW(64), .OW(32)) u_a (
    .clk(clk), .rst(rst), .idata(a_idata), .ivalid(a_ivalid), .iready(a_iready),
    .odata(a_odata), .ovalid(a_ovalid), .oready(a_oready)
  );
  width_adapter #(.IW(32), .OW(64)) u_b (
    .clk(clk), .rst(rst), .idata(b_idata), .ivalid(b_ivalid), .iready(b_iready),
    .odata(b_odata), .ovalid(b_ovalid), .oready(b_oready)
  );
  width_adapter #(.IW(24), .OW(16)) u_c (
    .clk(clk), .rst(rst), .idata(c_idata), .ivalid(c_ivalid), .iready(c_iready),
    .odata(c_odata), .ovalid(c_ovalid), .oready(c_oready)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  logic [31:0] bw [6] = '{32'hAAAA0001, 32'hBBBB0002, 32'h11112222, 32'h33334444, 32'hDEADBEEF, 32'h00C0FFEE};
  logic [31:0] q [$];
  initial begin
    rst = 1'b1;
    {a_ivalid, a_oready, b_ivalid, b_oready, c_ivalid, c_oready} = '0;
    a_idata = '0;
    b_idata = '0;
    c_idata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_a_ovalid", 64'(a_ovalid), 64'h0);
    chk("rst_a_iready", 64'(a_iready), 64'h1);
    chk("rst_a_odata", 64'(a_odata), 64'h0);
    chk("rst_b_ovalid", 64'(b_ovalid), 64'h0);
    chk("rst_b_iready", 64'(b_iready), 64'h1);
    chk("rst_c_odata", 64'(c_odata), 64'h0);
    chk("rst_c_iready", 64'(c_iready), 64'h1);
    a_oready = 1'b1;
    a_ivalid = 1'b1;
    a_idata = 64'h0123456789ABCDEF;
    step;
    a_ivalid = 1'b0;
    chk("dn_v0", 64'(a_ovalid), 64'h1);
    chk("dn_d0", 64'(a_odata), 64'h01234567);
    step;
    chk("dn_d1", 64'(a_odata), 64'h89ABCDEF);
    step;
    chk("dn_empty", 64'(a_ovalid), 64'h0);
    chk("dn_ready", 64'(a_iready), 64'h1);
    a_oready = 1'b0;
    a_ivalid = 1'b1;
    a_idata = 64'h0123456789ABCDEF;
    step;
    a_idata = 64'hFFFFFFFFFFFFFFFF;
    chk("stall_iready", 64'(a_iready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_odata", 64'(a_odata), 64'h01234567);
      chk("stall_ovalid", 64'(a_ovalid), 64'h1);
      step;
    end
    a_ivalid = 1'b0;
    a_oready = 1'b1;
    step;
    chk("stall_d1", 64'(a_odata), 64'h89ABCDEF);
    step;
    chk("stall_empty", 64'(a_ovalid), 64'h0);
    a_oready = 1'b0;
    a_ivalid = 1'b1;
    a_idata = 64'hCAFEF00D12345678;
    step;
    rst = 1'b1;
    a_oready = 1'b1;
    step;
    rst = 1'b0;
    a_ivalid = 1'b0;
    chk("mid_rst_ovalid", 64'(a_ovalid), 64'h0);
    chk("mid_rst_iready", 64'(a_iready), 64'h1);
    chk("mid_rst_odata", 64'(a_odata), 64'h0);
    b_oready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_ivalid = 1'b1;
      b_idata = bw[k];
      chk("up_iready", 64'(b_iready), 64'h1);
      if (k == 2 || k == 4) begin
        chk("up_ovalid", 64'(b_ovalid), 64'h1);
        chk("up_odata", b_odata, {bw[k-2], bw[k-1]});
      end
      step;
    end
    b_ivalid = 1'b0;
    chk("up_last", b_odata, {bw[4], bw[5]});
    step;
    chk("up_empty", 64'(b_ovalid), 64'h0);
    c_oready = 1'b1;
    c_ivalid = 1'b1;
    c_idata = 24'h123456;
    step;
    c_idata = 24'h789ABC;
    chk("odd_d0", 64'(c_odata), 64'h1234);
    chk("odd_full", 64'(c_iready), 64'h0);
    step;
    chk("odd_partial_v", 64'(c_ovalid), 64'h0);
    chk("odd_partial_r", 64'(c_iready), 64'h1);
    step;
    c_ivalid = 1'b0;
    chk("odd_d1", 64'(c_odata), 64'h5678);
    step;
    chk("odd_d2", 64'(c_odata), 64'h9ABC);
    chk("odd_bound_r", 64'(c_iready), 64'h1);
    step;
    chk("odd_empty", 64'(c_ovalid), 64'h0);
    for (int blk = 0; blk < 100; blk++) begin
      int sent;
      int got;
      int cyc;
      sent = 0;
      got = 0;
      cyc = 0;
      q.delete();
      while (got < 64 && cyc < 2000) begin
        a_ivalid = (sent < 32) && 1'($urandom_range(1));
        a_idata = {$urandom, $urandom};
        a_oready = 1'($urandom_range(1));
        if (a_ivalid && a_iready) begin
          q.push_back(a_idata[63:32]);
          q.push_back(a_idata[31:0]);
          sent++;
        end
        if (a_ovalid && a_oready) begin
          if (q.size() == 0) chk("rnd_extra", 64'(a_odata), 64'hXXXXXXXXXXXXXXXX);
          else chk("rnd_data", 64'(a_odata), 64'(q.pop_front()));
          got++;
        end
        step;
        cyc++;
      end
      chk("rnd_count", 64'(got), 64'd64);
      chk("rnd_left", 64'(q.size()), 64'd0);
    end
    a_ivalid = 1'b0;
    a_oready = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/width_adapter.md
WIDTH_ADAPTER -- requirements
Module: width_adapter

Interface
REQ-001 Parameter IW, default 64, input word width in bits; SHALL be >= 1.
REQ-002 Parameter OW, default 32, output word width in bits; SHALL be >= 1; IW and OW need not be multiples of each other.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 idata  input  IW  input word.
REQ-006 ivalid  input  1  input word valid.
REQ-007 iready  output  1  adapter can accept an input word this cycle.
REQ-008 odata  output  OW  output word.
REQ-009 ovalid  output  1  odata valid.
REQ-010 oready  input  1  sink accepts odata this cycle.

Function
REQ-011 Input transfer SHALL occur on a clock edge with ivalid && iready; output transfer on ovalid && oready.
REQ-012 The block SHALL treat the input as a contiguous MSB-first bitstream: idata[IW-1] of each accepted word first, words in acceptance order; outputs SHALL carry the same bitstream, odata[OW-1] first, with no bits dropped, duplicated or reordered.
REQ-013 Storage SHALL be a left-aligned bit buffer of BUFW = IW+OW bits plus a fill count cnt (0..BUFW); valid bits occupy buf[BUFW-1 -: cnt].
REQ-014 ovalid SHALL equal (cnt >= OW); odata SHALL equal buf[BUFW-1 -: OW]; both SHALL be functions of registers only.
REQ-015 iready SHALL equal (cnt <= BUFW-IW), i.e. cnt <= OW; it SHALL NOT depend on oready or ivalid.
REQ-016 On output transfer: buffer shifted left by OW, cnt -= OW.
REQ-017 On input transfer: idata written so its MSB lands at bit position BUFW-1-cnt', cnt' being cnt after any same-cycle output transfer; cnt += IW.
REQ-018 Simultaneous input and output transfer in one cycle SHALL be supported and SHALL apply REQ-016 then REQ-017.
REQ-019 Latency: a word accepted at edge N SHALL make ovalid visible after edge N if cnt reaches OW; no combinational ivalid->ovalid or oready->iready paths.
REQ-020 Throughput: with ivalid and oready held high, down-conversion (IW>OW) SHALL emit one output word every cycle after the first; up-conversion (IW<OW) SHALL accept one input word every cycle.
REQ-021 While ovalid && !oready, odata SHALL remain stable.
REQ-022 Partial data (0 < cnt < OW) SHALL be held indefinitely; no flush or padding.
REQ-023 Bits of buf outside the valid region SHALL be don't-care but SHALL NOT propagate into odata.

Reset
REQ-024 On rst: cnt=0, buf=0, hence ovalid=0, odata=0, iready=1 in the cycle after reset.
REQ-025 Reset mid-operation SHALL discard all buffered bits; ivalid/oready ignored during the rst cycle.

Structure
REQ-026 Single module, one always block for buf/cnt plus continuous assigns; no sub-module; no shared package (BUFW is a local parameter).
REQ-027 Count width SHALL be $clog2(BUFW+1) bits.

Verification
REQ-028 Reset: assert rst 2 cycles -> ovalid=0, iready=1, odata=0.
REQ-029 IW=64,OW=32, oready=1, single input 64'h0123456789ABCDEF -> odata 32'h01234567 next cycle, then 32'h89ABCDEF, then ovalid=0.
REQ-030 IW=64,OW=32, oready=0, ivalid=1 -> one word accepted, iready=0 afterwards (cnt=64), odata stable 32'h01234567 until oready rises.
REQ-031 IW=32,OW=64, inputs 32'hAAAA0001, 32'hBBBB0002 -> one output 64'hAAAA0001BBBB0002; input accepted every cycle under continuous oready.
REQ-032 IW=24,OW=16, inputs 24'h123456, 24'h789ABC -> outputs 16'h1234, 16'h5678, 16'h9ABC.
REQ-033 IW=64,OW=32, random 50% ivalid/oready, 32 inputs per block -> 64 outputs whose concatenation equals input concatenation; repeat 100 blocks with no count or data mismatch.
